// File: rtl/tt_um_nlp52_scan_pkg.sv
// Shared definitions for the majority scanner: state encoding, window count,
// seven-segment patterns and the fixed bidirectional-pin direction mask.
package tt_um_nlp52_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int NUM_WINDOWS = 6;

   // Segment order gfedcba, active-high
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;

   // uio[7:2] carry the hit mask out, uio[1:0] are the start/clear inputs
   localparam logic [7:0] UIO_OE_MASK = 8'hFC;

   // Hit count to display pattern; counts above 6 cannot occur and stay dark
   function automatic logic [6:0] seg_decode(input logic [2:0] val);
      logic [6:0] seg;
      case (val)
         3'd0:    seg = SEG_0;
         3'd1:    seg = SEG_1;
         3'd2:    seg = SEG_2;
         3'd3:    seg = SEG_3;
         3'd4:    seg = SEG_4;
         3'd5:    seg = SEG_5;
         3'd6:    seg = SEG_6;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/nlp52_majority3.sv
// Combinational 2-of-3 detector: high when at least two window bits are set.
module nlp52_majority3 (
   input  logic [2:0] win_i,
   output logic       maj_o
);

   assign maj_o = ((win_i[0] | win_i[1]) & win_i[2]) | (win_i[0] & win_i[1]);

endmodule

// File: rtl/tt_um_nlp52_majority_scanner.sv
// TinyTapeout top: snapshots the switches on a start edge, then steps one
// shared majority detector across the six 3-bit windows, one per prescaler
// tick, accumulating a hit mask and a hit count shown as a decimal digit.
module tt_um_nlp52_majority_scanner #(
   parameter int MAX_COUNT = 10_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   import tt_um_nlp52_scan_pkg::*;

   // A one-cycle period still needs a 1-bit counter
   localparam int             PW         = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(MAX_COUNT - 1);
   localparam logic [2:0]     LAST_IDX   = 3'(NUM_WINDOWS - 1);

   logic [1:0]    start_sync_q;
   logic          start_prev_q;
   logic [1:0]    clr_sync_q;
   logic          start_edge;
   logic          clr;

   state_e        state_q, state_d;
   logic [7:0]    snap_q, snap_d;
   logic [2:0]    idx_q, idx_d;
   logic [2:0]    hits_q, hits_d;
   logic [5:0]    mask_q, mask_d;
   logic [PW-1:0] presc_q, presc_d;

   logic [7:0]    snap_shift;
   logic [2:0]    win;
   logic          maj;
   logic          tick;

   // ena and the spare uio inputs are intentionally not used
   logic          unused_ok;
   assign unused_ok = &{1'b0, ena, uio_in[7:2]};

   // Two-flop synchronisers for start and clear, plus a history flop for start edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_sync_q <= 2'b00;
         start_prev_q <= 1'b0;
         clr_sync_q   <= 2'b00;
      end else begin
         start_sync_q <= {start_sync_q[0], uio_in[0]};
         start_prev_q <= start_sync_q[1];
         clr_sync_q   <= {clr_sync_q[0], uio_in[1]};
      end
   end

   assign start_edge = start_sync_q[1] & ~start_prev_q;
   assign clr        = clr_sync_q[1];

   // Window idx is snap[idx+2:idx]; shifting avoids an out-of-range part-select
   assign snap_shift = snap_q >> idx_q;
   assign win        = snap_shift[2:0];

   nlp52_majority3 u_maj (
      .win_i (win),
      .maj_o (maj)
   );

   assign tick = (presc_q == PRESC_LAST);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         snap_q  <= 8'h00;
         idx_q   <= 3'd0;
         hits_q  <= 3'd0;
         mask_q  <= 6'd0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         idx_q   <= idx_d;
         hits_q  <= hits_d;
         mask_q  <= mask_d;
         presc_q <= presc_d;
      end
   end

   // Next-state logic: clear overrides everything, start re-arms from IDLE or DONE
   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      idx_d   = idx_q;
      hits_d  = hits_q;
      mask_d  = mask_q;
      presc_d = presc_q;

      if (clr) begin
         state_d = ST_IDLE;
         hits_d  = 3'd0;
         mask_d  = 6'd0;
         presc_d = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_edge) begin
                  state_d = ST_SCAN;
                  snap_d  = ui_in;
                  idx_d   = 3'd0;
                  hits_d  = 3'd0;
                  mask_d  = 6'd0;
                  presc_d = '0;
               end
            end
            ST_SCAN: begin
               if (tick) begin
                  presc_d = '0;
                  mask_d  = mask_q | (6'(maj) << idx_q);
                  hits_d  = hits_q + 3'(maj);
                  if (idx_q == LAST_IDX) begin
                     state_d = ST_DONE;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign uo_out  = {(state_q == ST_SCAN), seg_decode(hits_q)};
   assign uio_out = {mask_q, 2'b00};
   assign uio_oe  = UIO_OE_MASK;

endmodule

// File: doc/tt_um_nlp52_majority_scanner.md
# tt_um_nlp52_majority_scanner

Sequencing controller for the pair/triple (2-of-3 majority) detector. On a start request it snapshots the eight input switches and steps one shared majority unit across the six 3-bit sliding windows, one window per prescaler tick. It records a per-window hit mask and a hit count, and drives the count as a decimal digit on the seven-segment display. It is a TinyTapeout user-module top that reuses the existing switch and display pinout.

## Interface
- MAX_COUNT, 10_000_000: prescaler period in clk cycles per window step; legal range ≥1.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  design enable; ignored, block always runs
- ui_in  in  8  switches; snapshot source
- uio_in  in  8  [0] start (level, edge-detected), [1] clear (level); [7:2] unused
- uo_out  out  8  [6:0] segments gfedcba of hit count, active-high; [7] busy
- uio_out  out  8  [7:2] hit mask bits 5..0; [1:0] = 0
- uio_oe  out  8  constant 8'hFC

## Operation
- Synchronisers: start and clear each pass through a 2-flop synchroniser. A third flop on start gives start_edge = sync & ~prev.
- Registers: state, snap[7:0], idx[2:0] (0..5), hits[2:0] (0..6), mask[5:0], presc (0..MAX_COUNT-1).
- Window i is snap[i+2:i]. maj = (b0|b1)&b2 | (b0&b1), i.e. true when ≥2 bits are set.
- IDLE:
  - start_edge → SCAN.
  - On entry: snap←ui_in (value at that clock edge), idx←0, hits←0, mask←0, presc←0.
- SCAN:
  - presc increments every cycle. tick = (presc==MAX_COUNT-1); presc wraps to 0 on tick.
  - On tick: mask[idx]←maj(window idx), hits←hits+maj.
  - On tick, if idx==5 → DONE; otherwise idx←idx+1.
  - start_edge is ignored.
- DONE:
  - Holds hits, mask and snap.
  - start_edge → SCAN, with the same entry actions as from IDLE.
- Clear: synchronised clear high in any state → IDLE, hits←0, mask←0, presc←0. Clear has priority over start_edge and over tick in the same cycle.
- Reset: all registers 0, state IDLE, synchroniser flops 0.
- Display decode, combinational from hits: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D.
- Busy: uo_out[7] = (state==SCAN).
- Mask and display update progressively during SCAN as each window completes.
- hits cannot overflow: the maximum is 6 in 3 bits.

## Timing
- Reset values: uo_out=8'h3F, uio_out=8'h00, uio_oe=8'hFC.
- Start latency: uio_in[0] first sampled high at edge k → start_edge during cycle k+1..k+2 → state=SCAN and snap captured at edge k+2.
- First tick occurs MAX_COUNT cycles after SCAN entry. DONE is reached 6·MAX_COUNT cycles after entry; busy is high for exactly 6·MAX_COUNT cycles.
- MAX_COUNT=1: one window per cycle.
- Clear latency: 2 synchroniser edges plus 1 state edge.
- ui_in changes after snapshot have no effect on the result.
- Start held high: only one scan, because it is edge-detected. A new scan requires start to go low and then high again.

## Structure
- Shared package tt_um_nlp52_scan_pkg holds:
  - state encoding (IDLE=0, SCAN=1, DONE=2)
  - NUM_WINDOWS=6
  - the 7 segment-pattern constants
  - UIO_OE_MASK=8'hFC
- Sub-module nlp52_majority3: a combinational 2-of-3 detector (3-bit in, 1-bit out), instantiated once on the muxed window.
- Top contains the synchronisers, FSM, prescaler, accumulators and display decode.

## Test plan
All scenarios use MAX_COUNT=4.
- Reset: assert rst_n=0 mid-simulation → uo_out=8'h3F, uio_out=8'h00, uio_oe=8'hFC immediately (async), state IDLE.
- ui_in=8'h07, start pulse → busy high for 24 cycles; final mask=6'b000011, uio_out=8'h0C, uo_out=8'h5B.
- ui_in=8'h55, start → mask=6'b010101, uio_out=8'h54, uo_out=8'h4F. Intermediate check: after 2nd tick, uio_out=8'h04.
- ui_in=8'hFF, start; change ui_in to 8'h00 and pulse start mid-scan → result unchanged (uo_out=8'h7D at DONE, uio_out=8'hFC), single 24-cycle busy.
- Clear asserted after 3rd tick of a scan → IDLE within 3 cycles, uo_out=8'h3F, uio_out=8'h00. A subsequent start with ui_in=8'h00 gives uo_out=8'h3F.
- Start and clear rising together → clear wins, state stays IDLE. Start held high across DONE → no re-scan until start toggles low and then high.
